im_boot_ctrl: RTL
=================

Name: im_boot_ctrl

Overview:
- Sequences the single-cycle CPU's instruction memory (1024 x 32-bit word array, asynchronous read, synchronous write) through three phases: zero-clear, program load from a valid/ready word stream, then run.
- Owns the memory's single address/write port and muxes it between the clear sweep, the loader stream and CPU fetch.
- Gates the CPU through cpu_run, so the PC never advances over a partially loaded image.

Parameters:
- DEPTH, 1024, number of instruction words (power of two).
- ADDR_W, 10, log2(DEPTH); word-index width.
- TEXT_BASE, 32'h0000_3000, byte address of word 0 as seen by fetch.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  loader word available.
- load_data  in  32  instruction word.
- load_last  in  1  qualifies final word of image.
- load_ready  out  1  controller accepts a word this cycle.
- reload  in  1  single-cycle request to restart clear+load from RUN.
- fetch_addr  in  32  CPU PC (byte address).
- fetch_instr  out  32  instruction returned to CPU.
- cpu_run  out  1  CPU may update PC/state.
- im_we  out  1  memory write enable.
- im_addr  out  ADDR_W  memory word index.
- im_wdata  out  32  memory write data.
- im_rdata  in  32  memory asynchronous read data.
- load_count  out  ADDR_W+1  words accepted in the current load.
- err_overflow  out  1  sticky: image exceeded DEPTH.
- err_fetch  out  1  sticky: misaligned or out-of-range fetch.

Behaviour:
- States: CLEAR, LOAD, RUN, encoded 2 bits; state, counters and error flags are registers; the im_* port is combinational from state and counters.
- Reset (synchronous, active-high): state=CLEAR, clr_ptr=0, load_count=0, err_overflow=0, err_fetch=0.
  - Output values in the first cycle after reset: cpu_run=0, load_ready=0, fetch_instr=0.
  - Reset asserted mid-LOAD or mid-RUN aborts immediately and restarts at CLEAR; partial memory contents are irrelevant because CLEAR rewrites them.
- CLEAR:
  - Outputs: im_we=1, im_addr=clr_ptr, im_wdata=0; clr_ptr increments each cycle.
  - When clr_ptr==DEPTH-1, that write completes, clr_ptr resets to 0 and state goes to LOAD.
  - Duration is exactly DEPTH cycles. load_ready=0, cpu_run=0.
- LOAD:
  - Outputs: load_ready=1, im_addr=load_count[ADDR_W-1:0], im_wdata=load_data, im_we=load_valid.
  - A word is accepted when load_valid && load_ready; the write and the load_count increment happen on that clock edge. Zero-latency: back-to-back valid gives one word per cycle.
  - Accepted word with load_last=1: go to RUN next cycle.
  - Accepted word with load_last=0 while load_count==DEPTH-1: the word is written, err_overflow is set, state goes to RUN and load_count reads DEPTH. Subsequent words see load_ready=0.
  - load_valid=0: no write, state unchanged (the loader may idle indefinitely).
- RUN:
  - Outputs: cpu_run=1, load_ready=0, im_we=0.
  - Address: off = fetch_addr - TEXT_BASE (32-bit wrap), im_addr = off[ADDR_W+1:2], fetch_instr = im_rdata (same cycle, combinational).
  - Fetch error condition: off[1:0]!=0, or off >= DEPTH*4.
    - fetch_instr is forced to 0 (nop).
    - err_fetch is set on the next clock edge and stays set until reset.
  - reload=1: next state CLEAR, cpu_run drops the following cycle, load_count=0, clr_ptr=0; error flags are kept.
- reload is ignored in CLEAR and LOAD.
- In CLEAR and LOAD, fetch_instr=0, fetch_addr is ignored and no fetch errors are flagged.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_CLEAR=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2;
  - TEXT_BASE and the DEPTH/ADDR_W defaults, reused by the PC reset value and the IM.
- One natural sub-module, im_fetch_xlate: the combinational byte-to-word translation plus the misalign/range check. It is shared with the data-side address decoder later.
- FSM and counters stay in the top level.

Test Plan:
- Reset 1 cycle, hold load_valid=0 -> im_we=1 for exactly 1024 cycles at addresses 0..1023 with wdata 0; load_ready rises on cycle 1025; cpu_run=0 throughout.
- Load stream of 3 words 0x3402_0001, 0x3403_0002, 0x0043_2021 (last on the third), with load_valid deasserted for 2 cycles between words 1 and 2 -> writes at indexes 0, 1, 2 only; load_count=3; cpu_run=1 the next cycle.
- In RUN: fetch_addr=0x0000_3008 -> im_addr=2, fetch_instr=0x0043_2021; fetch_addr=0x0000_3002 -> fetch_instr=0 and err_fetch=1 next cycle; fetch_addr=0x0000_2FFC -> fetch_instr=0 (out of range).
- Stream 1025 words with no load_last -> 1024 writes, err_overflow=1, RUN entered after word index 1023, the 1025th word never accepted (load_ready=0).
- reload pulse in RUN -> CLEAR next cycle, 1024 clear writes, new 1-word image loaded; err_fetch is still set from the earlier scenario.
- reset asserted midway through LOAD after 5 words -> state CLEAR, load_count=0, flags cleared, load_ready=0, full clear sweep repeats.

Source files
------------

// File: rtl/im_boot_ctrl_pkg.sv
// im_boot_ctrl_pkg
//   Shared constants and types for the instruction-memory boot controller:
//   default memory geometry, the byte address fetch sees for word 0, and
//   the controller state encoding. Also reused by the PC reset value and
//   the instruction memory itself.
package im_boot_ctrl_pkg;

   localparam int          IM_DEPTH     = 1024;
   localparam int          IM_ADDR_W    = 10;
   localparam logic [31:0] IM_TEXT_BASE = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

endpackage

// File: rtl/im_boot_ctrl_if.sv
// im_boot_ctrl_if
//   Valid/ready word stream from the program loader into the boot controller.
//   Ports:
//     load_valid  loader has a word available
//     load_data   32-bit instruction word
//     load_last   marks the final word of the image
//     load_ready  controller accepts a word this cycle
//   Modports: master = loader side, slave = controller side.
interface im_boot_ctrl_if;
   import im_boot_ctrl_pkg::*;

   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;

   modport master (output load_valid, output load_data, output load_last,
                   input  load_ready);
   modport slave  (input  load_valid, input  load_data, input  load_last,
                   output load_ready);

endinterface

// File: rtl/im_boot_ctrl_fetch_xlate.sv
// im_fetch_xlate
//   Combinational byte-address to word-index translation with alignment and
//   range check. Shared with the data-side address decoder.
//   Ports:
//     byte_addr_i  32-bit byte address
//     word_idx_o   word index into a 2**ADDR_W word array
//     err_o        address misaligned or outside [BASE, BASE + 4*2**ADDR_W)
module im_fetch_xlate
   import im_boot_ctrl_pkg::*;
#(
   parameter int          ADDR_W = IM_ADDR_W,
   parameter logic [31:0] BASE   = IM_TEXT_BASE
) (
   input  logic [31:0]       byte_addr_i,
   output logic [ADDR_W-1:0] word_idx_o,
   output logic              err_o
);

   logic [31:0] off;

   // Subtraction wraps, so addresses below BASE become huge offsets and
   // fall out through the same upper-bits range test.
   assign off        = byte_addr_i - BASE;
   assign word_idx_o = off[ADDR_W+1:2];
   assign err_o      = (off[1:0] != 2'b00) || (off[31:ADDR_W+2] != '0);

endmodule

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl
//   Sequences the instruction memory through zero-clear, program load and
//   run, owning the memory's single address/write port and gating the CPU.
//   Ports:
//     clk, reset     clock and synchronous active-high reset
//     ld             loader word stream (slave side)
//     reload         one-cycle request to restart clear+load from RUN
//     fetch_addr     CPU PC (byte address); fetch_instr returned word
//     cpu_run        CPU may advance
//     im_we/im_addr/im_wdata/im_rdata  memory port (async read)
//     load_count     words accepted in current load
//     err_overflow   sticky: image longer than DEPTH
//     err_fetch      sticky: misaligned or out-of-range fetch in RUN
module im_boot_ctrl
   import im_boot_ctrl_pkg::*;
#(
   parameter int          DEPTH     = IM_DEPTH,
   parameter int          ADDR_W    = IM_ADDR_W,
   parameter logic [31:0] TEXT_BASE = IM_TEXT_BASE
) (
   input  logic              clk,
   input  logic              reset,
   im_boot_ctrl_if.slave     ld,
   input  logic              reload,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_instr,
   output logic              cpu_run,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   input  logic [31:0]       im_rdata,
   output logic [ADDR_W:0]   load_count,
   output logic              err_overflow,
   output logic              err_fetch
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              err_overflow_q, err_overflow_d;
   logic              err_fetch_q, err_fetch_d;

   logic [ADDR_W-1:0] fetch_idx;
   logic              fetch_err;

   im_fetch_xlate #(
      .ADDR_W (ADDR_W),
      .BASE   (TEXT_BASE)
   ) u_xlate (
      .byte_addr_i (fetch_addr),
      .word_idx_o  (fetch_idx),
      .err_o       (fetch_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_CLEAR;
         clr_ptr_q      <= '0;
         load_count_q   <= '0;
         err_overflow_q <= 1'b0;
         err_fetch_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         clr_ptr_q      <= clr_ptr_d;
         load_count_q   <= load_count_d;
         err_overflow_q <= err_overflow_d;
         err_fetch_q    <= err_fetch_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      clr_ptr_d      = clr_ptr_q;
      load_count_d   = load_count_q;
      err_overflow_d = err_overflow_q;
      err_fetch_d    = err_fetch_q;
      im_we          = 1'b0;
      im_addr        = '0;
      im_wdata       = '0;
      ld.load_ready  = 1'b0;
      cpu_run        = 1'b0;
      fetch_instr    = '0;

      case (state_q)
         ST_CLEAR: begin
            im_we     = 1'b1;
            im_addr   = clr_ptr_q;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
               clr_ptr_d = '0;
               state_d   = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // Ready is unconditional here, so valid alone qualifies a write.
            ld.load_ready = 1'b1;
            im_addr       = load_count_q[ADDR_W-1:0];
            im_wdata      = ld.load_data;
            im_we         = ld.load_valid;
            if (ld.load_valid) begin
               load_count_d = load_count_q + 1'b1;
               if (ld.load_last) begin
                  state_d = ST_RUN;
               end else if (load_count_q == {1'b0, LAST_IDX}) begin
                  // Memory full without a last marker: keep what fits, run it.
                  err_overflow_d = 1'b1;
                  state_d        = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            cpu_run     = 1'b1;
            im_addr     = fetch_idx;
            fetch_instr = fetch_err ? 32'h0 : im_rdata;
            if (fetch_err) begin
               err_fetch_d = 1'b1;
            end
            if (reload) begin
               state_d      = ST_CLEAR;
               load_count_d = '0;
               clr_ptr_d    = '0;
            end
         end

         default: state_d = ST_CLEAR;
      endcase
   end

   assign load_count   = load_count_q;
   assign err_overflow = err_overflow_q;
   assign err_fetch    = err_fetch_q;

endmodule
